// File: rtl/mem_access_unit.sv
// Load/store sequencer driving a byte-addressed data memory with a one-cycle registered read.
// Build option: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned halfword/word requests.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_DONE
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  state_t      state, next_state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        capture;
  logic        req_bad;
  logic [31:0] load_val;
  logic [31:0] merge;

  logic        mem_read_d, mem_write_d, done_d, err_d;
  logic [31:0] mem_addr_d, mem_wd_d, rdata_d;

  assign capture = (state == S_IDLE) && req;
  assign busy    = (state != S_IDLE);

  // Every access touches a 4-byte window starting at addr, whatever the size.
  always_comb begin
    req_bad = (size == 2'b11) || (addr > LAST_ADDR);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (size == SZ_HALF && addr[0])          req_bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != '0)  req_bad = 1'b1;
`endif
  end

  always_comb begin
    unique case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'h0, mem_rd[7:0]}   : {{24{mem_rd[7]}}, mem_rd[7:0]};
      SZ_HALF: load_val = uns_q ? {16'h0, mem_rd[15:0]}  : {{16{mem_rd[15]}}, mem_rd[15:0]};
      default: load_val = mem_rd;
    endcase
  end

  always_comb begin
    unique case (size_q)
      SZ_BYTE: merge = {mem_rd[31:8], wdata_q[7:0]};
      SZ_HALF: merge = {mem_rd[31:16], wdata_q[15:0]};
      default: merge = wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (req_bad)                     next_state = S_DONE;
          else if (we && size == SZ_WORD)  next_state = S_WR_ISSUE;
          else                             next_state = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: next_state = S_RD_WAIT;
      S_RD_WAIT:  next_state = we_q ? S_WR_ISSUE : S_DONE;
      S_WR_ISSUE: next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output logic: values for the next cycle, registered below so strobes never glitch.
  always_comb begin
    mem_read_d  = (next_state == S_RD_ISSUE);
    mem_write_d = (next_state == S_WR_ISSUE);
    done_d      = (next_state == S_DONE);
    err_d       = capture && req_bad;
    mem_addr_d  = mem_addr;
    mem_wd_d    = mem_wd;
    rdata_d     = rdata;
    if (capture && !req_bad) begin
      mem_addr_d = addr;
      if (we && size == SZ_WORD) mem_wd_d = wdata;
    end
    if (state == S_RD_WAIT) begin
      if (we_q) mem_wd_d = merge;
      else      rdata_d  = load_val;
    end
  end

  // mem_addr doubles as the latched request address for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, matching the hardware.
      we_q    <= we;
      size_q  <= size;
      uns_q   <= uns;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      rdata     <= '0;
    end else begin
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      done      <= done_d;
      err       <= err_d;
      mem_addr  <= mem_addr_d;
      mem_wd    <= mem_wd_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array memory model plus a request-level reference.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
  logic        busy, done, err, mem_read, mem_write;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory seen by the DUT, and the reference image the model updates per request.
  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] rd_q;
  logic        load_en;
  assign mem_rd = rd_q;

  function automatic logic [31:0] env_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
    end else if (mem_write && mem_addr <= 32'(MEM_BYTES - 4)) begin
      for (int i = 0; i < 4; i++) mem[int'(mem_addr) + i] <= mem_wd[8*i +: 8];
    end
    if (mem_read && mem_addr <= 32'(MEM_BYTES - 4)) rd_q <= env_word(int'(mem_addr));
  end

  int          n_rd = 0, n_wr = 0, n_both = 0;
  logic [31:0] last_wd = '0;
  always @(negedge clk) begin
    if (mem_read)  n_rd <= n_rd + 1;
    if (mem_write) begin
      n_wr    <= n_wr + 1;
      last_wd <= mem_wd;
    end
    if (mem_read && mem_write) n_both <= n_both + 1;
  end

  int          total = 0, bad = 0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'h0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  task automatic sync_memory();
    @(negedge clk) load_en = 1'b1;
    @(negedge clk) load_en = 1'b0;
  endtask

  // One request, checked against what the rules say it must do.
  task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned ai;
    int          nb, lat, lat_e, rd_e, wr_e, rd0, wr0, both0;
    logic        bad_e;
    logic [31:0] word, exp_wd;
    ai    = a;
    bad_e = (sz == 2'b11) || (ai > MEM_BYTES - 4);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (sz == 2'b01 && ai % 2 != 0) bad_e = 1'b1;
    if (sz == 2'b10 && ai % 4 != 0) bad_e = 1'b1;
`endif
    nb     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_wd = '0;
    if (bad_e) begin
      lat_e = 1; rd_e = 0; wr_e = 0;
    end else if (w) begin
      lat_e = (nb == 4) ? 2 : 4;
      rd_e  = (nb == 4) ? 0 : 1;
      wr_e  = 1;
      for (int i = 0; i < nb; i++) ref_mem[ai + i] = d[8*i +: 8];
      exp_wd = ref_word(ai);
    end else begin
      lat_e = 3; rd_e = 1; wr_e = 0;
      word  = ref_word(ai);
      if (nb == 1)      exp_rdata = u ? 32'(word[7:0])  : 32'(int'($signed(word[7:0])));
      else if (nb == 2) exp_rdata = u ? 32'(word[15:0]) : 32'(int'($signed(word[15:0])));
      else              exp_rdata = word;
    end

    rd0 = n_rd; wr0 = n_wr; both0 = n_both;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    check("busy_after_req", 32'(busy), 32'h1);
    lat = 1;
    while (!done && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_e));
    check("err", 32'(err), 32'(bad_e));
    check("rdata", rdata, exp_rdata);
    check("read_strobes", 32'(n_rd - rd0), 32'(rd_e));
    check("write_strobes", 32'(n_wr - wr0), 32'(wr_e));
    check("rd_wr_overlap", 32'(n_both - both0), 32'h0);
    if (wr_e != 0) check("mem_wd", last_wd, exp_wd);
    if (ai <= MEM_BYTES - 4) check("mem_window", env_word(ai), ref_word(ai));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'h0);
    check("idle_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    int unsigned a;
    logic [31:0] saved;
    int          wr0;
    rst = 1'b1; load_en = 1'b0;
    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h84;
    sync_memory();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Directed cases from the preload at bytes 16..19
    run_op(1'b0, 2'b10, 1'b0, 32'd16, 32'h0);
    check("tp_load_word", rdata, 32'h84332211);
    run_op(1'b0, 2'b00, 1'b0, 32'd19, 32'h0);
    check("tp_load_byte_s", rdata, 32'hFFFFFF84);
    run_op(1'b0, 2'b00, 1'b1, 32'd19, 32'h0);
    check("tp_load_byte_u", rdata, 32'h00000084);
    run_op(1'b0, 2'b01, 1'b0, 32'd18, 32'h0);
    check("tp_load_half_s", rdata, 32'hFFFF8433);
    run_op(1'b1, 2'b00, 1'b0, 32'd16, 32'h000000AB);
    check("tp_store_byte_wd", last_wd, 32'h843322AB);
    run_op(1'b0, 2'b10, 1'b1, 32'd16, 32'h0);
    check("tp_store_byte_rb", rdata, 32'h843322AB);
    run_op(1'b1, 2'b10, 1'b0, 32'd1020, 32'hDEADBEEF);
    run_op(1'b1, 2'b10, 1'b0, 32'd1021, 32'hDEADBEEF);
    run_op(1'b0, 2'b11, 1'b0, 32'd8, 32'h0);
    run_op(1'b0, 2'b10, 1'b0, 32'd17, 32'h0);
    run_op(1'b1, 2'b01, 1'b0, 32'd1019, 32'h0000CAFE);

    // Reset during RD_WAIT of a sub-word store must abort the pending write.
    saved = ref_word(100);
    wr0   = n_wr;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'd100; wdata = 32'h5A;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_rdata = '0;
    check("abort_no_write", 32'(n_wr - wr0), 32'h0);
    check("abort_mem_unchanged", env_word(100), saved);
    run_op(1'b1, 2'b01, 1'b0, 32'd100, 32'h00001234);

    // Randomized traffic, biased toward the top-of-memory boundary
    for (int n = 0; n < 120; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MEM_BYTES - 9, MEM_BYTES + 2))
                                      : 32'($urandom_range(0, MEM_BYTES - 1));
      run_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
